pep_ks_result_unpack: RTL and testbench

PEP_KS_RESULT_UNPACK -- requirements
Module: pep_ks_result_unpack

---
 rtl/pep_ks_result_unpack.sv | 156 +++++++++++++++
 tb/tb_pep_ks_result_unpack.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pep_ks_result_unpack.sv
// pep_ks_result_unpack
// Serializes a key-switch result packet (one coefficient index, up to
// BATCH_PBS_NB LWE slots) into a stream of single coefficients. Only the
// slots between the read and write pointers are emitted, in pointer order.
// A running expected coefficient index flags out-of-order packets.
module pep_ks_result_unpack #(
   parameter int BATCH_PBS_NB = 8,
   parameter int PID_W        = 3,
   parameter int LWE_COEF_W   = 21,
   parameter int KS_CORR_W    = 8,
   parameter int LWE_K_P1     = 631,
   parameter int KS_LOOP_W    = 10
) (
   input  logic                               clk,
   input  logic                               s_rst,
   input  logic [KS_LOOP_W-1:0]               in_ks_loop,
   input  logic [PID_W:0]                     in_wp,
   input  logic [PID_W:0]                     in_rp,
   input  logic [BATCH_PBS_NB*LWE_COEF_W-1:0] in_lwe_a,
   input  logic [BATCH_PBS_NB*KS_CORR_W-1:0]  in_corr_a,
   input  logic                               in_vld,
   output logic                               in_rdy,
   output logic [PID_W-1:0]                   out_pid,
   output logic [KS_LOOP_W-1:0]               out_ks_loop,
   output logic [LWE_COEF_W-1:0]              out_lwe,
   output logic [KS_CORR_W-1:0]               out_corr,
   output logic                               out_body,
   output logic                               out_vld,
   input  logic                               out_rdy,
   output logic                               seq_err
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   localparam logic [PID_W:0]     BATCH_NB_C  = (PID_W+1)'(BATCH_PBS_NB);
   localparam logic [PID_W:0]     ONE_C       = (PID_W+1)'(1);
   localparam logic [PID_W:0]     ZERO_C      = (PID_W+1)'(0);
   localparam logic [KS_LOOP_W-1:0] LAST_LOOP_C = KS_LOOP_W'(LWE_K_P1-1);
   localparam logic [KS_LOOP_W-1:0] LOOP_ONE_C  = KS_LOOP_W'(1);
   localparam logic [KS_LOOP_W-1:0] LOOP_ZERO_C = KS_LOOP_W'(0);

   // Control state
   logic [0:0]           state_r;
   logic                 out_vld_r;
   logic [KS_LOOP_W-1:0] exp_loop_r;
   logic                 seq_err_r;

   // Held packet
   logic [PID_W-1:0]      rp_r;
   logic [PID_W:0]        elt_nb_r;
   logic [PID_W:0]        slot_r;
   logic [LWE_COEF_W-1:0] lwe_hold_r  [BATCH_PBS_NB];
   logic [KS_CORR_W-1:0]  corr_hold_r [BATCH_PBS_NB];

   // Registered output coefficient
   logic [PID_W-1:0]      out_pid_r;
   logic [KS_LOOP_W-1:0]  out_ks_loop_r;
   logic [LWE_COEF_W-1:0] out_lwe_r;
   logic [KS_CORR_W-1:0]  out_corr_r;
   logic                  out_body_r;

   // Combinational helpers
   logic [PID_W:0]        diff_s;
   logic [PID_W:0]        in_elt_nb_s;
   logic [PID_W:0]        nxt_slot_s;
   logic [PID_W-1:0]      nxt_idx_s;
   logic                  last_s;
   logic                  out_hs_s;
   logic                  in_rdy_s;
   logic                  in_hs_s;

   // Number of valid slots in the incoming packet; an empty difference means a full packet
   always_comb begin
      diff_s = in_wp - in_rp;
      if (diff_s == ZERO_C) begin
         in_elt_nb_s = BATCH_NB_C;
      end else if (diff_s > BATCH_NB_C) begin
         in_elt_nb_s = BATCH_NB_C;
      end else begin
         in_elt_nb_s = diff_s;
      end
   end

   // Handshake decode; a new packet is taken while the last slot leaves, so there is no bubble
   always_comb begin
      nxt_slot_s = slot_r + ONE_C;
      nxt_idx_s  = nxt_slot_s[PID_W-1:0];
      last_s     = (slot_r == (elt_nb_r - ONE_C));
      out_hs_s   = out_vld_r & out_rdy;
      in_rdy_s   = ~s_rst & ((state_r == ST_IDLE) | (out_hs_s & last_s));
      in_hs_s    = in_vld & in_rdy_s;
   end

   // State, output valid and sequence tracking
   always_ff @(posedge clk) begin
      if (s_rst) begin
         state_r    <= ST_IDLE;
         out_vld_r  <= 1'b0;
         exp_loop_r <= LOOP_ZERO_C;
         seq_err_r  <= 1'b0;
      end else begin
         if (in_hs_s) begin
            state_r   <= ST_DRAIN;
            out_vld_r <= 1'b1;
            if (in_ks_loop != exp_loop_r) begin
               seq_err_r <= 1'b1;
            end
            if (exp_loop_r == LAST_LOOP_C) begin
               exp_loop_r <= LOOP_ZERO_C;
            end else begin
               exp_loop_r <= exp_loop_r + LOOP_ONE_C;
            end
         end else if (out_hs_s && last_s) begin
            state_r   <= ST_IDLE;
            out_vld_r <= 1'b0;
         end else begin
            state_r   <= state_r;
            out_vld_r <= out_vld_r;
         end
      end
   end

   // Packet hold and output coefficient registers; slot 0 is presented straight from the input
   always_ff @(posedge clk) begin
      if (in_hs_s) begin
         rp_r     <= in_rp[PID_W-1:0];
         elt_nb_r <= in_elt_nb_s;
         slot_r   <= ZERO_C;
         for (int j = 0; j < BATCH_PBS_NB; j++) begin
            lwe_hold_r[j]  <= in_lwe_a[j*LWE_COEF_W +: LWE_COEF_W];
            corr_hold_r[j] <= in_corr_a[j*KS_CORR_W +: KS_CORR_W];
         end
         out_pid_r     <= in_rp[PID_W-1:0];
         out_ks_loop_r <= in_ks_loop;
         out_lwe_r     <= in_lwe_a[LWE_COEF_W-1:0];
         out_corr_r    <= in_corr_a[KS_CORR_W-1:0];
         out_body_r    <= (in_ks_loop == LAST_LOOP_C);
      end else if (out_hs_s && !last_s) begin
         slot_r     <= nxt_slot_s;
         out_pid_r  <= rp_r + nxt_idx_s;
         out_lwe_r  <= lwe_hold_r[nxt_idx_s];
         out_corr_r <= corr_hold_r[nxt_idx_s];
      end
   end

   assign in_rdy      = in_rdy_s;
   assign out_vld     = out_vld_r;
   assign out_pid     = out_pid_r;
   assign out_ks_loop = out_ks_loop_r;
   assign out_lwe     = out_lwe_r;
   assign out_corr    = out_corr_r;
   assign out_body    = out_body_r;
   assign seq_err     = seq_err_r;

endmodule

// File: tb/tb_pep_ks_result_unpack.sv
// Directed bench for pep_ks_result_unpack: a scoreboard of expected
// coefficients is filled as packets are accepted and drained by a monitor.
module tb_pep_ks_result_unpack;

   localparam int NB   = 8;
   localparam int PW   = 3;
   localparam int LW   = 21;
   localparam int CW   = 8;
   localparam int KP1  = 631;
   localparam int KLW  = 10;
   localparam int CO_W = PW + KLW + LW + CW + 1;

   logic               clk = 1'b0;
   logic               s_rst;
   logic [KLW-1:0]     in_ks_loop;
   logic [PW:0]        in_wp;
   logic [PW:0]        in_rp;
   logic [NB*LW-1:0]   in_lwe_a;
   logic [NB*CW-1:0]   in_corr_a;
   logic               in_vld;
   logic               in_rdy;
   logic [PW-1:0]      out_pid;
   logic [KLW-1:0]     out_ks_loop;
   logic [LW-1:0]      out_lwe;
   logic [CW-1:0]      out_corr;
   logic               out_body;
   logic               out_vld;
   logic               out_rdy;
   logic               seq_err;

   int                 checks = 0;
   int                 failures = 0;
   int                 obs_cnt = 0;
   int                 stall_n = 0;
   int                 pkt_n = 0;
   longint             cyc = 0;
   longint             last_hs_cyc = 0;
   logic               prev_stall = 1'b0;
   logic [CO_W-1:0]    prev_coef = '0;
   logic [CO_W-1:0]    exp_q[$];
   logic               stall_done;

   always #5 clk = ~clk;

   pep_ks_result_unpack #(
      .BATCH_PBS_NB(NB), .PID_W(PW), .LWE_COEF_W(LW),
      .KS_CORR_W(CW), .LWE_K_P1(KP1), .KS_LOOP_W(KLW)
   ) dut (
      .clk(clk), .s_rst(s_rst), .in_ks_loop(in_ks_loop), .in_wp(in_wp),
      .in_rp(in_rp), .in_lwe_a(in_lwe_a), .in_corr_a(in_corr_a),
      .in_vld(in_vld), .in_rdy(in_rdy), .out_pid(out_pid),
      .out_ks_loop(out_ks_loop), .out_lwe(out_lwe), .out_corr(out_corr),
      .out_body(out_body), .out_vld(out_vld), .out_rdy(out_rdy),
      .seq_err(seq_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CO_W-1:0] mk_coef(input logic [PW-1:0] pid, input logic [KLW-1:0] ks,
                                                input logic [LW-1:0] lwe, input logic [CW-1:0] corr,
                                                input logic body);
      return {pid, ks, lwe, corr, body};
   endfunction

   function automatic logic [LW-1:0] lwe_pat(input int p, input int j);
      return LW'((p * 131 + j * 977 + 5) ^ (j << 15));
   endfunction

   function automatic logic [CW-1:0] corr_pat(input int p, input int j);
      return CW'(p * 7 + j * 29 + 1);
   endfunction

   // Cycle counter for throughput measurement
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: scoreboard compare on handshake, stability check across stalls
   always @(negedge clk) begin
      if (prev_stall) begin
         stall_n <= stall_n + 1;
         chk("stable", {out_vld, mk_coef(out_pid, out_ks_loop, out_lwe, out_corr, out_body)},
             {1'b1, prev_coef});
      end
      if (out_vld === 1'b1 && out_rdy === 1'b1) begin
         obs_cnt     <= obs_cnt + 1;
         last_hs_cyc <= cyc + 1;
         chk("q_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0)
            chk("coef", mk_coef(out_pid, out_ks_loop, out_lwe, out_corr, out_body), exp_q.pop_front());
      end
      prev_stall <= (out_vld === 1'b1) && (out_rdy === 1'b0) && (s_rst === 1'b0);
      prev_coef  <= mk_coef(out_pid, out_ks_loop, out_lwe, out_corr, out_body);
   end

   task automatic send(input int ks, input int rp, input int wp);
      logic [PW:0] d;
      int elt;
      int p;
      bit acc;
      p = pkt_n;
      pkt_n++;
      for (int j = 0; j < NB; j++) begin
         in_lwe_a[j*LW +: LW]  = lwe_pat(p, j);
         in_corr_a[j*CW +: CW] = corr_pat(p, j);
      end
      in_ks_loop = KLW'(ks);
      in_rp      = (PW+1)'(rp);
      in_wp      = (PW+1)'(wp);
      in_vld     = 1'b1;
      d   = (PW+1)'(wp - rp);
      elt = (d == 0) ? NB : int'(d);
      acc = 1'b0;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge clk);
         if (in_rdy === 1'b1) begin
            @(posedge clk);
            acc = 1'b1;
         end
      end
      if (acc) begin
         for (int j = 0; j < elt; j++)
            exp_q.push_back(mk_coef(PW'((rp + j) % NB), KLW'(ks), lwe_pat(p, j),
                                    corr_pat(p, j), ks == KP1 - 1));
      end else begin
         chk("accept", in_rdy, 1);
      end
      #1 in_vld = 1'b0;
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while (i < 2000 && (exp_q.size() != 0 || out_vld !== 1'b0)) begin
         @(negedge clk);
         i++;
      end
      chk("drain_q", exp_q.size(), 0);
      chk("drain_vld", out_vld, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      s_rst  = 1'b1;
      in_vld = 1'b0;
      @(negedge clk);
      chk("rst_in_rdy", in_rdy, 0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_seq_err", seq_err, 0);
      chk("rst_in_rdy2", in_rdy, 0);
      @(posedge clk);
      #1 s_rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("post_rst_in_rdy", in_rdy, 1);
      chk("post_rst_out_vld", out_vld, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      longint a;
      s_rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
      in_ks_loop = '0; in_wp = '0; in_rp = '0; in_lwe_a = '0; in_corr_a = '0;
      do_reset();

      // Full packet: latency 1, pids 0..7, in_rdy only on last slot
      send(0, 0, 8);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk("lat_vld", out_vld, 1);
         chk("pid_seq", out_pid, c - 1);
         chk("in_rdy_drain", in_rdy, c == 8);
      end
      @(negedge clk);
      chk("idle_vld", out_vld, 0);
      @(posedge clk);
      #1;

      // Partial packet with pointer wrap: pids 6,7,0 only
      base = obs_cnt;
      send(1, 6, 9);
      wait_drain();
      chk("partial_cnt", obs_cnt - base, 3);

      // Out-of-order index sets a sticky error
      chk("seq_err_pre", seq_err, 0);
      send(5, 0, 8);
      chk("seq_err_set", seq_err, 1);
      send(3, 2, 4);
      wait_drain();
      chk("seq_err_sticky", seq_err, 1);

      // Reset after three slots discards the rest
      do_reset();
      base = obs_cnt;
      send(0, 0, 8);
      repeat (3) @(posedge clk);
      #1 s_rst = 1'b1;
      out_rdy = 1'b0;
      @(negedge clk);
      chk("rst_mid_in_rdy", in_rdy, 0);
      @(posedge clk);
      #1 s_rst = 1'b0;
      exp_q.delete();
      chk("rst_mid_cnt", obs_cnt - base, 3);
      @(negedge clk);
      chk("rst_mid_vld", out_vld, 0);
      chk("rst_mid_rdy", in_rdy, 1);
      out_rdy = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_mid_none", obs_cnt - base, 3);
      @(posedge clk);
      #1;
      send(0, 3, 3);
      chk("rst_mid_seq", seq_err, 0);
      wait_drain();

      // Random output stalls
      base = obs_cnt;
      stall_done = 1'b0;
      fork
         begin
            send(1, 2, 7);
            send(2, 5, 5);
            send(3, 7, 8);
            send(4, 12, 2);
            wait_drain();
            stall_done = 1'b1;
         end
         begin
            while (!stall_done) begin
               @(posedge clk);
               #1;
               if (!stall_done) out_rdy = 1'($urandom_range(0, 1));
            end
         end
      join
      out_rdy = 1'b1;
      chk("stall_cnt", obs_cnt - base, 20);
      chk("stall_seen", stall_n > 0, 1);
      chk("stall_seq", seq_err, 0);

      // Full index sweep back to back
      do_reset();
      a = 0;
      for (int p = 0; p < KP1; p++) begin
         send(p, p % NB, p % NB + NB);
         if (p == 0) a = cyc;
      end
      wait_drain();
      chk("sweep_no_bubble", last_hs_cyc - a, 5048);
      chk("sweep_seq", seq_err, 0);
      send(0, 1, 1);
      chk("sweep_wrap_seq", seq_err, 0);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
